// File: rtl/ring_osc_trim_ctrl.sv
// ring_osc_trim_ctrl: closed-loop thermometer trim of a ring oscillator against a slow reference
module ring_osc_trim_ctrl #(
    parameter int NSTAGES    = 13,
    parameter int CNT_W      = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int INIT_LEVEL = NSTAGES
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   manual,
    input  logic                   ref_in,
    input  logic [CNT_W-1:0]       div,
    input  logic [2*NSTAGES-1:0]   manual_trim,
    output logic [2*NSTAGES-1:0]   trim,
    output logic                   locked,
    output logic [CNT_W-1:0]       period
);
    localparam int W   = 2 * NSTAGES;
    localparam int LW  = $clog2(W + 1);
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0] INIT_TRIM = ~({W{1'b1}} << INIT_LEVEL);
    localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2;
    logic [1:0]       state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [LW-1:0]    lvl;
    logic [LCW-1:0]   inband;
    logic [W-1:0]     thermo;
    logic [CNT_W:0]   p, hi_lim, p_tol;
    logic             run, ref_rise, meas, fast, slow;
    assign run      = enable & ~manual;
    assign ref_rise = s2 & ~s3;
    assign meas     = run && state == MEAS && ref_rise;
    // captured period saturates with the counter so a stalled reference reads as full scale
    assign p        = {1'b0, cnt} + {{CNT_W{1'b0}}, ~&cnt};
    assign hi_lim   = {1'b0, div} + (CNT_W+1)'(TOL);
    assign p_tol    = p + (CNT_W+1)'(TOL);
    assign fast     = p > hi_lim;
    assign slow     = p_tol < {1'b0, div};
    always_comb begin
        thermo = '0;
        for (int i = 0; i < W; i++) thermo[i] = lvl > LW'(i);
    end
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            {s1, s2, s3} <= 3'b000;
            state        <= IDLE;
            cnt          <= '0;
        end else begin
            s1 <= ref_in;
            s2 <= s1;
            s3 <= s2;
            state <= !run ? IDLE : state == IDLE ? ARM : (state == ARM && ref_rise) ? MEAS : state;
            cnt   <= (!run || state == IDLE || ref_rise) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
        end
    end
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            lvl    <= LW'(INIT_LEVEL);
            inband <= '0;
            locked <= 1'b0;
            period <= '0;
            trim   <= INIT_TRIM;
        end else begin
            trim <= manual ? manual_trim : thermo;
            if (!run) begin
                inband <= '0;
                locked <= 1'b0;
            end else if (meas) begin
                period <= p[CNT_W-1:0];
                if (fast) begin
                    lvl    <= lvl == LW'(W) ? lvl : lvl + LW'(1);
                    inband <= '0;
                    locked <= 1'b0;
                end else if (slow) begin
                    lvl    <= lvl == '0 ? lvl : lvl - LW'(1);
                    inband <= '0;
                    locked <= 1'b0;
                end else begin
                    inband <= inband < LCW'(LOCK_CNT) ? inband + LCW'(1) : inband;
                    locked <= inband >= LCW'(LOCK_CNT - 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// tb_ring_osc_trim_ctrl: randomized scoreboard bench for ring_osc_trim_ctrl against a per-edge model
module tb_ring_osc_trim_ctrl;
    logic        clock = 1'b0, resetb = 1'b1, enable = 1'b0, manual = 1'b0, ref_in = 1'b0;
    logic [7:0]  div = 8'd32;
    logic [25:0] manual_trim = '0;
    logic [25:0] trim;
    logic        locked;
    logic [7:0]  period;
    int checks = 0, errors = 0;
    typedef struct { int per; int lvl; bit lock; } exp_t;
    exp_t exp_q[$];
    int  m_lvl = 13, m_in = 0, m_per = 0, prev_t = 0, div_v = 32;
    bit  m_lock = 0, m_armed = 0;
    ring_osc_trim_ctrl dut (
        .clock(clock), .resetb(resetb), .enable(enable), .manual(manual), .ref_in(ref_in),
        .div(div), .manual_trim(manual_trim), .trim(trim), .locked(locked), .period(period)
    );
    always #5 clock = ~clock;
    function automatic logic [25:0] th(int l);
        logic [25:0] t = '0;
        for (int i = 0; i < l; i++) t[i] = 1'b1;
        return t;
    endfunction
    task automatic chk(string n, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask
    // one reference edge as seen by an ideal measurement: spacing since the previous edge
    task automatic model_edge();
        int p;
        if (!m_armed) m_armed = 1;
        else begin
            p = prev_t > 255 ? 255 : prev_t;
            m_per = p;
            if (p > div_v + 1) begin m_lvl = m_lvl < 26 ? m_lvl + 1 : 26; m_in = 0; end
            else if (p + 1 < div_v) begin m_lvl = m_lvl > 0 ? m_lvl - 1 : 0; m_in = 0; end
            else if (m_in < 4) m_in++;
        end
        m_lock = m_in == 4;
        exp_q.push_back('{m_per, m_lvl, m_lock});
    endtask
    task automatic pulse(int t);
        model_edge();
        ref_in = 1'b1;
        repeat (t / 2) @(negedge clock);
        ref_in = 1'b0;
        repeat (t - t / 2) @(negedge clock);
        prev_t = t;
    endtask
    task automatic set_div(int d);
        div = 8'(d);
        div_v = d;
    endtask
    task automatic unarm();
        m_armed = 0; m_in = 0; m_lock = 0;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge ref_in);
            repeat (6) @(negedge clock);
            if (exp_q.size() == 0) chk("sb_nonempty", 0, 1);
            else begin
                e = exp_q.pop_front();
                chk("period", int'(period), e.per);
                chk("trim", int'(trim), int'(th(e.lvl)));
                chk("locked", int'(locked), int'(e.lock));
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end
    initial begin
        int d;
        #3 resetb = 1'b0;
        #1;
        chk("rst_trim", int'(trim), int'(th(13)));
        chk("rst_locked", int'(locked), 0);
        chk("rst_period", int'(period), 0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clock);
        repeat (4) pulse(40);
        repeat (7) pulse(32);
        repeat (20) pulse(40);
        repeat (30) pulse(20);
        repeat (16) pulse(32);
        set_div(36);
        repeat (6) pulse(32);
        set_div(32);
        for (int i = 0; i < 10; i++) pulse(i % 2 ? 31 : 33);
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) set_div($urandom_range(26, 40));
            pulse(div_v + $urandom_range(0, 6) - 3);
        end
        set_div(32);
        pulse(300);
        pulse(40);
        repeat (6) pulse(32);
        chk("pre_manual_locked", int'(locked), 1);
        manual = 1'b1;
        manual_trim = 26'h0AAAAAA;
        unarm();
        @(negedge clock);
        chk("manual_trim", int'(trim), 32'h0AAAAAA);
        chk("manual_locked", int'(locked), 0);
        repeat (5) @(negedge clock);
        chk("manual_hold", int'(trim), 32'h0AAAAAA);
        manual = 1'b0;
        @(negedge clock);
        chk("manual_release", int'(trim), int'(th(m_lvl)));
        repeat (2) @(negedge clock);
        repeat (7) pulse(32);
        enable = 1'b0;
        unarm();
        @(negedge clock);
        chk("disable_locked", int'(locked), 0);
        enable = 1'b1;
        repeat (2) @(negedge clock);
        pulse(40);
        repeat (7) pulse(33);
        chk("pre_reset_locked", int'(locked), 1);
        #2 resetb = 1'b0;
        #1;
        chk("async_trim", int'(trim), int'(th(13)));
        chk("async_locked", int'(locked), 0);
        chk("async_period", int'(period), 0);
        unarm();
        m_lvl = 13; m_per = 0;
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        pulse(40);
        repeat (3) pulse(40);
        repeat (10) @(negedge clock);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
